dm_access_arbiter: RTL
======================

// Module: dm_access_arbiter
// PURPOSE
//   Two-port arbiter and sequencer in front of the single-port data memory.
//   Port 0 is the pipeline MEM stage; port 1 is the debug/DMA loader.
//   Each cycle it grants at most one request and drives the memory address, write data and op.
//   It checks alignment, squashes bad writes, and returns registered read data one cycle after the grant.
//   Round-robin arbitration; an optional lock lets one port burst for a bounded number of cycles.
// PARAMETERS
//   MAX_BURST  4   max consecutive grants to a locked port before a forced hand-over (>=1)
//   ADDR_W     32  byte-address width
// PORTS
//   clk          in   1          clock
//   reset        in   1          synchronous, active-high
//   req_valid    in   2          per-port request valid
//   req_lock     in   2          per-port "keep grant next cycle" hint
//   req_addr0/1  in   ADDR_W     byte address, port 0/1
//   req_wdata0/1 in   32         store data, port 0/1 (low byte/half used for sb/sh)
//   req_op0/1    in   DMOP_SIZE  [3:1] size/sign code, [0] write enable
//   req_ready    out  2          one-hot grant this cycle (combinational)
//   mem_addr     out  ADDR_W     to memory
//   mem_wdata    out  32         to memory
//   mem_op       out  DMOP_SIZE  to memory; bit0 forced 0 when no grant or misaligned
//   mem_rdata    in   32         from memory, combinational, already size/sign-extended
//   rsp_valid    out  2          one-hot, registered, 1 cycle after grant
//   rsp_data     out  32         read data latched at grant (0 for writes)
//   rsp_err      out  1          misaligned access flag, valid with rsp_valid
// BEHAVIOUR
//   Reset: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rr_ptr=0, state=ARB, burst_cnt=0.
//   The combinational mem_* outputs show mem_op=0 during reset.
//   Handshake: a transfer occurs when req_valid[i] && req_ready[i].
//     The requester holds addr/wdata/op stable until the transfer completes.
//     At most one ready bit per cycle, and never ready without valid.
//   States:
//     ARB: grant the single valid port.
//       If both are valid, grant port rr_ptr, then set rr_ptr to the other port.
//       If the granted port has req_lock=1 and MAX_BURST>1, go to LOCKED(owner), burst_cnt=1.
//     LOCKED(owner): owner has priority.
//       Grant owner if valid, then burst_cnt++.
//       Return to ARB when any of these holds:
//         owner req_lock=0, owner req_valid=0, or burst_cnt==MAX_BURST-1 on this grant.
//       On a forced hand-over, rr_ptr points at the other port.
//       If the owner is not valid, the other port may be granted in the same cycle (no idle bubble).
//   Alignment:
//     word (DMOP_WORD) needs addr[1:0]==0.
//     half (DMOP_HALF/HALFU) needs addr[0]==0.
//     Byte ops are always aligned.
//     Misaligned access: memory not written (mem_op[0]=0); next cycle rsp_err=1 and rsp_data=0.
//   Response: at posedge after a grant,
//     rsp_valid <= onehot(grant); rsp_data <= (read && aligned) ? mem_rdata : 0.
//     rsp_valid is 0 in cycles with no grant.
//   Latency: read data is available exactly 1 cycle after the handshake.
//     Back-to-back grants give 1 response per cycle.
//   Pass-through: mem_addr/mem_wdata follow the granted port.
//     With no grant they follow port 0 and mem_op[0]=0, so a write is impossible.
//   Reset mid-burst: lock, counter, pointer and pending response are all dropped.
//     No response is emitted for a grant in the reset cycle.
//   Unknown op codes are treated as a no-op read.
//     Ready is still given, rsp_data=0, rsp_err=0.
// STRUCTURE
//   DMOP_* codes and DMOP_SIZE stay in the shared macros header; add ARB_ARB/ARB_LOCKED state codes there.
//   One sub-module: dm_align_check (op, addr[1:0] -> aligned), instanced once per port.
//   Everything else is flat: FSM, round-robin pointer, burst counter and response register.
// TESTING
//   1. Only port 0 issues sw 0x1234_5678 @0x10, then lw @0x10.
//      -> lw rsp_valid=2'b01, rsp_data=0x12345678 one cycle after grant.
//   2. Both ports valid for 4 cycles with no lock.
//      -> grants alternate 01,10,01,10 starting from rr_ptr=0.
//   3. Port 1 locked with MAX_BURST=4 while port 0 is continuously valid.
//      -> port 1 gets 4 grants, then port 0 is granted.
//   4. sh @0x3 and lw @0x2.
//      -> mem_op[0]=0; memory unchanged; rsp_err=1, rsp_data=0.
//   5. Reset asserted during a LOCKED burst with a pending response.
//      -> next cycle rsp_valid=0, req_ready=0; after release, both valid -> port 0 granted first.
//   6. lb @0x13 after sw 0x80FF_0000 @0x10.
//      -> rsp_data=0xFFFFFF80; lbu at the same address -> 0x00000080.

Source files
------------

// File: rtl/dm_access_arbiter_pkg.sv
// Shared definitions for the data-memory access arbiter: memory op encoding,
// arbiter state codes and an op-validity helper.
package dm_access_arbiter_pkg;

    localparam int DMOP_SIZE = 4;

    // Size/sign codes carried in op[3:1]; op[3] marks the zero-extending loads.
    localparam logic [2:0] DMOP_BYTE  = 3'd0;
    localparam logic [2:0] DMOP_HALF  = 3'd1;
    localparam logic [2:0] DMOP_WORD  = 3'd2;
    localparam logic [2:0] DMOP_BYTEU = 3'd4;
    localparam logic [2:0] DMOP_HALFU = 3'd5;

    typedef enum logic {
        ARB_ARB    = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic dmop_known(input logic [DMOP_SIZE-1:0] op);
        logic known;
        case (op[DMOP_SIZE-1:1])
            DMOP_BYTE, DMOP_HALF, DMOP_WORD, DMOP_BYTEU, DMOP_HALFU: known = 1'b1;
            default:                                               known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: two request ports plus
// the shared one-hot response channel.
interface dm_access_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    import dm_access_arbiter_pkg::*;

    logic [1:0]           req_valid;
    logic [1:0]           req_lock;
    logic [ADDR_W-1:0]    req_addr0;
    logic [ADDR_W-1:0]    req_addr1;
    logic [31:0]          req_wdata0;
    logic [31:0]          req_wdata1;
    logic [DMOP_SIZE-1:0] req_op0;
    logic [DMOP_SIZE-1:0] req_op1;
    logic [1:0]           req_ready;
    logic [1:0]           rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_lock, req_addr0, req_addr1,
               req_wdata0, req_wdata1, req_op0, req_op1,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_lock, req_addr0, req_addr1,
               req_wdata0, req_wdata1, req_op0, req_op1,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/dm_access_arbiter_align_check.sv
// Natural-alignment check for one memory op; byte and unknown ops never fault.
module dm_align_check
    import dm_access_arbiter_pkg::*;
(
    input  logic [DMOP_SIZE-1:0] op_i,
    input  logic [1:0]           addr_i,
    output logic                 aligned_o
);

    // Alignment requirement by access size
    always_comb begin
        aligned_o = 1'b1;
        case (op_i[DMOP_SIZE-1:1])
            DMOP_WORD:              aligned_o = (addr_i == 2'b00);
            DMOP_HALF, DMOP_HALFU:  aligned_o = ~addr_i[0];
            default:                aligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Two-port round-robin arbiter with bounded lock bursts in front of the
// single-port data memory; returns registered read data one cycle after grant.
module dm_access_arbiter
    import dm_access_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    dm_access_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [DMOP_SIZE-1:0] mem_op_o,
    input  logic [31:0]          mem_rdata_i
);

    localparam int               CNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic             LOCK_EN  = 1'(MAX_BURST > 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic                 gnt_any_s, gnt_port_s, gnt_new_s;
    logic [1:0]           gnt_s;
    logic                 aligned0_s, aligned1_s, sel_aligned_s;
    logic                 sel_known_s, sel_write_s, sel_read_s;
    logic [DMOP_SIZE-1:0] sel_op_s;
    logic [1:0]           rsp_valid_q;
    logic [31:0]          rsp_data_q;
    logic                 rsp_err_q;

    dm_align_check u_align0 (.op_i(bus.req_op0), .addr_i(bus.req_addr0[1:0]), .aligned_o(aligned0_s));
    dm_align_check u_align1 (.op_i(bus.req_op1), .addr_i(bus.req_addr1[1:0]), .aligned_o(aligned1_s));

    // Grant selection and next-state for the arbitration FSM
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_any_s   = 1'b0;
        gnt_port_s  = 1'b0;
        gnt_new_s   = 1'b0;
        if (reset) begin
            state_d = ARB_ARB;
        end else begin
            case (state_q)
                ARB_ARB: begin
                    gnt_new_s = |bus.req_valid;
                    if (bus.req_valid == 2'b11) begin
                        gnt_port_s = rr_ptr_q;
                        rr_ptr_d   = ~rr_ptr_q;
                    end else begin
                        gnt_port_s = bus.req_valid[1] & ~bus.req_valid[0];
                    end
                end
                ARB_LOCKED: begin
                    if (bus.req_valid[owner_q]) begin
                        gnt_any_s   = 1'b1;
                        gnt_port_s  = owner_q;
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                        if (!bus.req_lock[owner_q] || (burst_cnt_q == CNT_LAST)) begin
                            state_d     = ARB_ARB;
                            rr_ptr_d    = ~owner_q;
                            burst_cnt_d = '0;
                        end else begin
                            state_d = ARB_LOCKED;
                        end
                    end else begin
                        // Owner idle: hand over at once so the other port sees no bubble
                        state_d     = ARB_ARB;
                        burst_cnt_d = '0;
                        gnt_new_s   = bus.req_valid[~owner_q];
                        gnt_port_s  = bus.req_valid[~owner_q] ? ~owner_q : 1'b0;
                    end
                end
                default: state_d = ARB_ARB;
            endcase
            if (gnt_new_s) begin
                gnt_any_s = 1'b1;
                if (LOCK_EN && bus.req_lock[gnt_port_s]) begin
                    state_d     = ARB_LOCKED;
                    owner_d     = gnt_port_s;
                    burst_cnt_d = CNT_W'(1);
                end else begin
                    state_d     = ARB_ARB;
                    burst_cnt_d = '0;
                end
            end else begin
                owner_d = owner_q;
            end
        end
    end

    assign gnt_s         = gnt_any_s ? (gnt_port_s ? 2'b10 : 2'b01) : 2'b00;
    assign sel_op_s      = gnt_port_s ? bus.req_op1 : bus.req_op0;
    assign sel_aligned_s = gnt_port_s ? aligned1_s : aligned0_s;
    assign sel_known_s   = dmop_known(sel_op_s);
    assign sel_write_s   = gnt_any_s & sel_aligned_s & sel_known_s & sel_op_s[0];
    assign sel_read_s    = gnt_any_s & sel_aligned_s & sel_known_s & ~sel_op_s[0];

    assign mem_addr_o    = gnt_port_s ? bus.req_addr1 : bus.req_addr0;
    assign mem_wdata_o   = gnt_port_s ? bus.req_wdata1 : bus.req_wdata0;
    assign mem_op_o      = reset ? '0 : {sel_op_s[DMOP_SIZE-1:1], sel_write_s};

    assign bus.req_ready = gnt_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // FSM, round-robin pointer and burst counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_ARB;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Response register: one-hot grant, read data and alignment fault
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= gnt_s;
            rsp_data_q  <= sel_read_s ? mem_rdata_i : 32'h0000_0000;
            rsp_err_q   <= gnt_any_s & ~sel_aligned_s;
        end
    end

endmodule
